// File: rtl/thunderbird_if.sv
// Switch inputs and sequencer command outputs for thunderbird_ctrl.
interface thunderbird_if;
    logic sw_left;
    logic sw_right;
    logic sw_brk;
    logic sw_hzd;
    logic sw_rlight;
    logic step;
    logic left;
    logic right;
    logic brk;
    logic hzd;
    logic rlight;
    logic dimclk;

    modport master (
        output sw_left, sw_right, sw_brk, sw_hzd, sw_rlight,
        input  step, left, right, brk, hzd, rlight, dimclk
    );

    modport slave (
        input  sw_left, sw_right, sw_brk, sw_hzd, sw_rlight,
        output step, left, right, brk, hzd, rlight, dimclk
    );
endinterface

// File: rtl/thunderbird_ctrl.sv
// Tail-light input conditioner: switch sync/debounce, step and dimming clocks,
// and a step-aligned brake/hazard/turn arbiter with a 4-step sweep lock.
module thunderbird_ctrl #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned STEP_DIV  = 8,
    parameter int unsigned DIM_DIV   = 2
) (
    input logic         clk,
    input logic         rst,
    thunderbird_if.slave bus
);
    localparam int unsigned NSW    = 5;
    localparam int unsigned DBC_W  = $clog2(DB_CYCLES) + 1;
    localparam int unsigned STEP_W = $clog2(STEP_DIV);
    localparam int unsigned DIM_W  = (DIM_DIV > 1) ? $clog2(DIM_DIV) : 1;
    localparam int unsigned I_L    = 0;
    localparam int unsigned I_R    = 1;
    localparam int unsigned I_B    = 2;
    localparam int unsigned I_H    = 3;
    localparam int unsigned I_RL   = 4;

    typedef enum logic [1:0] {IDLE, TURN_L, TURN_R, HAZ} state_t;

    logic [NSW-1:0]    raw;
    logic [NSW-1:0]    s1;
    logic [NSW-1:0]    s;
    logic [NSW-1:0]    db;
    logic [DBC_W-1:0]  dbc [NSW];
    logic [STEP_W-1:0] step_cnt;
    logic [DIM_W-1:0]  dim_cnt;
    logic              step_q;
    logic              dimclk_q;
    logic              left_q;
    logic              right_q;
    logic              hzd_q;
    logic              brk_q;
    logic              req_h;
    logic              req_l;
    logic              req_r;
    logic              eval_idle;
    state_t            state;
    state_t            state_nxt;
    logic [1:0]        seq;
    logic [1:0]        seq_nxt;

    assign raw = {bus.sw_rlight, bus.sw_hzd, bus.sw_brk, bus.sw_right, bus.sw_left};

    // Two-flop synchronizer followed by a per-input persistence counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s  <= '0;
            db <= '0;
            for (int i = 0; i < NSW; i++) dbc[i] <= '0;
        end else begin
            s1 <= raw;
            s  <= s1;
            for (int i = 0; i < NSW; i++) begin
                if (s[i] == db[i]) begin
                    dbc[i] <= '0;
                end else if (dbc[i] == DBC_W'(DB_CYCLES - 1)) begin
                    db[i]  <= s[i];
                    dbc[i] <= '0;
                end else begin
                    dbc[i] <= dbc[i] + DBC_W'(1);
                end
            end
        end
    end

    // Step enable: one cycle high after each divider wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_cnt <= '0;
            step_q   <= 1'b0;
        end else if (step_cnt == STEP_W'(STEP_DIV - 1)) begin
            step_cnt <= '0;
            step_q   <= 1'b1;
        end else begin
            step_cnt <= step_cnt + STEP_W'(1);
            step_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dim_cnt  <= '0;
            dimclk_q <= 1'b0;
        end else if (dim_cnt == DIM_W'(DIM_DIV - 1)) begin
            dim_cnt  <= '0;
            dimclk_q <= ~dimclk_q;
        end else begin
            dim_cnt <= dim_cnt + DIM_W'(1);
        end
    end

    assign req_h = db[I_H] | (db[I_L] & db[I_R]);
    assign req_l = db[I_L] & ~db[I_R] & ~db[I_H];
    assign req_r = db[I_R] & ~db[I_L] & ~db[I_H];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            seq   <= '0;
        end else if (step_q) begin
            state <= state_nxt;
            seq   <= seq_nxt;
        end
    end

    // A turn mid-sweep only advances seq; every other case is a fresh arbitration
    always_comb begin
        state_nxt = state;
        seq_nxt   = seq;
        eval_idle = 1'b1;
        case (state)
            TURN_L, TURN_R: begin
                if (!req_h && (seq != 2'd3)) begin
                    seq_nxt   = seq + 2'd1;
                    eval_idle = 1'b0;
                end
            end
            default: eval_idle = 1'b1;
        endcase
        if (eval_idle) begin
            seq_nxt = '0;
            if (req_h)      state_nxt = HAZ;
            else if (req_l) state_nxt = TURN_L;
            else if (req_r) state_nxt = TURN_R;
            else            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
            hzd_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else if (step_q) begin
            left_q  <= (state_nxt == TURN_L);
            right_q <= (state_nxt == TURN_R);
            hzd_q   <= (state_nxt == HAZ);
            brk_q   <= db[I_B];
        end
    end

    assign bus.step   = step_q;
    assign bus.dimclk = dimclk_q;
    assign bus.left   = left_q;
    assign bus.right  = right_q;
    assign bus.hzd    = hzd_q;
    assign bus.brk    = brk_q;
    assign bus.rlight = db[I_RL];
endmodule

// File: tb/tb_thunderbird_ctrl.sv
// Bench for thunderbird_ctrl: directed table, corner sequences, and random
// switch activity checked every cycle against a timing-level reference model.
module tb_thunderbird_ctrl;
    localparam int DB = 4;
    localparam int SD = 8;
    localparam int DD = 2;
    localparam int HN = DB + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] sw  = '0;
    int         nvec = 0;
    int         nerr = 0;

    thunderbird_if bif ();
    assign bif.sw_left   = sw[0];
    assign bif.sw_right  = sw[1];
    assign bif.sw_brk    = sw[2];
    assign bif.sw_hzd    = sw[3];
    assign bif.sw_rlight = sw[4];

    thunderbird_ctrl #(.DB_CYCLES(DB), .STEP_DIV(SD), .DIM_DIV(DD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bif.rlight, bif.hzd, bif.brk, bif.right, bif.left};
    endfunction

    // Reference model: edge count since reset, raw-sample history, sweep progress
    int unsigned k;
    logic [4:0]  hist [HN];
    logic [4:0]  mdb;
    int          dir;   // 0 none, 1 left, 2 right, 3 hazard
    int          swp;   // steps already spent in the current sweep
    logic        m_step, m_brk, hr, lr, rr, alldiff;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            k = 0; mdb = '0; dir = 0; swp = 0; m_step = 1'b0; m_brk = 1'b0;
            for (int j = 0; j < HN; j++) hist[j] = '0;
        end else begin
            k++;
            if (m_step) begin
                hr = mdb[3] | (mdb[0] & mdb[1]);
                lr = mdb[0] & ~mdb[1] & ~mdb[3];
                rr = mdb[1] & ~mdb[0] & ~mdb[3];
                if (hr) dir = 3;
                else if ((dir == 1 || dir == 2) && swp < 3) swp++;
                else if (lr) begin dir = 1; swp = 0; end
                else if (rr) begin dir = 2; swp = 0; end
                else dir = 0;
                m_brk = mdb[2];
            end
            for (int j = HN - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = sw;
            for (int b = 0; b < 5; b++) begin
                alldiff = 1'b1;
                for (int d = 0; d < DB; d++) if (hist[2+d][b] == mdb[b]) alldiff = 1'b0;
                if (alldiff) mdb[b] = ~mdb[b];
            end
            m_step = ((k % SD) == 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("model", 32'({bif.step, bif.dimclk, outs()}),
                32'({m_step, ((k / DD) % 2) == 1, mdb[4], dir == 3, m_brk, dir == 2, dir == 1}));
            chk("exclusive", 32'((bif.left & bif.right) | (bif.left & bif.hzd) | (bif.right & bif.hzd)), 32'(0));
        end
    end

    task automatic check_clocks(input int n);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            chk("step_phase", 32'(bif.step), 32'((i % SD) == 0));
            chk("dimclk_phase", 32'(bif.dimclk), 32'(((i / DD) % 2) == 1));
        end
    endtask

    task automatic wait_bit(input int idx, input logic val, input int maxc, input string name);
        logic [4:0] o;
        int n;
        n = 0;
        o = outs();
        while (o[idx] !== val && n < maxc) begin
            @(posedge clk); #1;
            o = outs();
            n++;
        end
        chk(name, 32'(o[idx]), 32'(val));
    endtask

    task automatic count_high(input int idx, output int n);
        logic [4:0] o;
        n = 0;
        o = outs();
        while (o[idx] === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
            o = outs();
        end
    endtask

    task automatic hold(input logic [4:0] v, input int cycles);
        sw = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [4:0] sw;
        int         cycles;
        logic [4:0] exp;   // {rlight, hzd, brk, right, left}
    } vec_t;

    vec_t tbl [11];
    int   n;
    logic g;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{5'b00000, 16, 5'b00000};
        tbl[1]  = '{5'b00001, 20, 5'b00001};
        tbl[2]  = '{5'b00101, 20, 5'b00101};
        tbl[3]  = '{5'b01000, 20, 5'b01000};
        tbl[4]  = '{5'b00011, 20, 5'b01000};
        tbl[5]  = '{5'b00010, 20, 5'b00010};
        tbl[6]  = '{5'b00000, 80, 5'b00000};
        tbl[7]  = '{5'b10000, 12, 5'b10000};
        tbl[8]  = '{5'b00000, 12, 5'b00000};
        tbl[9]  = '{5'b00100, 20, 5'b00100};
        tbl[10] = '{5'b00000, 20, 5'b00000};

        #12;
        chk("reset_outs", 32'({bif.step, bif.dimclk, outs()}), 32'(0));
        @(negedge clk); rst = 1'b1;
        check_clocks(24);

        // Short pulse is rejected; a held one is granted
        hold(5'b00001, 3);
        sw = '0; g = 1'b0;
        repeat (60) begin @(posedge clk); #1; g = g | bif.left; end
        chk("glitch_reject", 32'(g), 32'(0));
        hold(5'b00001, 8);
        sw = '0;
        wait_bit(0, 1'b1, 30, "held8_grant");
        hold(5'b00000, 60);

        for (int i = 0; i < 11; i++) begin
            hold(tbl[i].sw, tbl[i].cycles);
            chk($sformatf("table_%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Sweep lock after the request vanishes
        sw = 5'b00001;
        wait_bit(0, 1'b1, 40, "lock_grant");
        sw = '0;
        count_high(0, n);
        chk("lock_len", 32'(n), 32'(32));
        hold(5'b00000, 40);

        // Direction change requested at seq 1
        sw = 5'b00001;
        wait_bit(0, 1'b1, 40, "dir_grant");
        repeat (8) @(posedge clk);
        #1;
        sw = 5'b00010;
        count_high(0, n);
        chk("dir_left_len", 32'(n), 32'(24));
        chk("dir_right", 32'(outs()), 32'(5'b00010));
        hold(5'b00000, 80);

        // Hazard preempts a right turn mid-sweep
        sw = 5'b00010;
        wait_bit(1, 1'b1, 40, "haz_turn_grant");
        repeat (8) @(posedge clk);
        #1;
        sw = 5'b01000;
        wait_bit(3, 1'b1, 20, "haz_preempt");
        chk("haz_preempt_outs", 32'(outs()), 32'(5'b01000));
        sw = '0;
        wait_bit(3, 1'b0, 20, "haz_release");
        chk("haz_release_outs", 32'(outs()), 32'(0));
        hold(5'b00000, 20);

        // Brake with left turn, then asynchronous reset mid-cycle
        sw = 5'b00101;
        n = 0;
        while (outs() !== 5'b00101 && n < 40) begin @(posedge clk); #1; n++; end
        chk("brk_with_left", 32'(outs()), 32'(5'b00101));
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("async_reset", 32'({bif.step, bif.dimclk, outs()}), 32'(0));
        sw = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        check_clocks(24);

        // Random switch activity with occasional mid-cycle resets
        for (int s = 0; s < 150; s++) begin
            logic [4:0] mask;
            mask = ($urandom_range(0, 1) == 1) ? 5'b11111 : 5'b00011;
            sw = 5'($urandom) & mask;
            if ($urandom_range(0, 29) == 0) begin
                @(posedge clk); #3;
                rst = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
            end
            repeat ($urandom_range(1, 40)) @(posedge clk);
            #1;
        end
        sw = '0;
        repeat (60) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/thunderbird_ctrl.md
# thunderbird_ctrl

Input conditioner and turn-request scheduler for the tail-light sequencer. It synchronizes and debounces the raw driver switches and generates the pattern-advance `step` enable and the `dimclk` dimming clock. It arbitrates brake, hazard and turn requests into clean, step-aligned `left`/`right`/`brk`/`hzd` commands for the pattern state machine. A granted turn direction is held for one full 4-step sweep, so the pattern never flips direction mid-sweep.

## Interface
- `DB_CYCLES`, 4: consecutive cycles an input must differ from its debounced value before the debounced value changes; ≥1.
- `STEP_DIV`, 8: clk cycles per `step` pulse; ≥2.
- `DIM_DIV`, 2: clk cycles per `dimclk` half-period; ≥1.
- `clk`  in  1  single system clock; all flops rise-edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `sw_left`, `sw_right`, `sw_brk`, `sw_hzd`, `sw_rlight`  in  1 each  raw asynchronous switch inputs.
- `step`  out  1  one-cycle pattern-advance enable.
- `left`, `right`, `brk`, `hzd`  out  1 each  registered commands, updated only on step edges.
- `rlight`  out  1  debounced running-light request, not step-aligned.
- `dimclk`  out  1  square-wave dimming clock.

## Operation
- **Synchronizer:** each `sw_*` input passes through a 2-flop synchronizer (`s`).
- **Debounce:** each input has a counter `dbc` (width $clog2(DB_CYCLES)+1) and a debounced value `db`.
  - If `s == db`: `dbc <= 0`.
  - Else if `dbc == DB_CYCLES-1`: `db <= s`, `dbc <= 0`.
  - Else: `dbc++`.
  - A pulse shorter than `DB_CYCLES` cycles never changes `db`.
- **Step divider:** counter `0..STEP_DIV-1`, wraps to 0. `step` is registered and is high for the cycle following the edge where the count wraps.
- **Dimming clock:** counter `0..DIM_DIV-1`. `dimclk` toggles on every wrap.
- **Request decode (combinational from `db`):**
  - `req_h = db_hzd | (db_left & db_right)`
  - `req_l = db_left & ~db_right & ~db_hzd`
  - `req_r = db_right & ~db_left & ~db_hzd`
- **Arbiter FSM** (states IDLE, TURN_L, TURN_R, HAZ; 2-bit `seq`). The FSM advances only on edges where `step == 1`.
  - IDLE:
    - `req_h` → HAZ.
    - else `req_l` → TURN_L with `seq <= 0`.
    - else `req_r` → TURN_R with `seq <= 0`.
    - else stay IDLE.
  - TURN_L / TURN_R:
    - `req_h` → HAZ (hazard preempts at any `seq`).
    - else if `seq < 3`: `seq++` and stay, regardless of request changes (sweep lock).
    - else (`seq == 3`): same-direction request → stay with `seq <= 0`; opposite request → other TURN with `seq <= 0`; no request → IDLE.
  - HAZ:
    - `req_h` → stay.
    - else evaluate exactly as IDLE (`req_l` → TURN_L, `req_r` → TURN_R, none → IDLE).
- **Outputs** (registered on step edges):
  - `left = (next == TURN_L)`, `right = (next == TURN_R)`, `hzd = (next == HAZ)`.
  - `brk <= db_brk`; brake is independent of the FSM and combines with turns.
  - At most one of `left`/`right`/`hzd` is 1 at any time.
- `rlight = db_rlight`, continuous.

## Timing
- **Reset (`rst = 0`):** takes effect immediately, asynchronously. All synchronizers, `db`, counters and `seq` clear to 0; FSM enters IDLE; all outputs are 0, including `dimclk` and `step`.
- **After reset release:** the first `step` is high during cycle `STEP_DIV` (1-based), then repeats every `STEP_DIV` cycles. `dimclk` first rises after `DIM_DIV` cycles; its period is `2*DIM_DIV`.
- **Input latency:** a stable raw change first sampled at edge E0 updates `db` at edge E0+DB_CYCLES+1.
- **Command latency:** a command changes on the first edge where `step == 1` after its `db` change, and is visible the cycle after that edge.
- **Turn hold:** a granted turn holds for at least 4 step periods unless preempted by hazard.
- **Reset mid-sweep:** the sweep is abandoned with no residual state. `seq` is 0 when a new turn is granted.
- **Simultaneous edges:**
  - If `db` changes on the same edge as a step, the old `db` value is used.
  - A hazard request and `seq == 3` on the same step resolve to HAZ.

## Test plan
Defaults apply: DB_CYCLES=4, STEP_DIV=8, DIM_DIV=2.
- **Reset and clocks:** `rst = 0` → all outputs 0. Release `rst` → `step` high in cycles 8, 16, 24…; `dimclk` toggles every 2 cycles (period 4).
- **Glitch rejection:** `sw_left` high for 3 cycles, then low → `left` stays 0 forever. Held for 8 cycles → `left = 1` after the next step.
- **Sweep lock:** `sw_left` held until `left = 1`, then dropped → `left` stays 1 for exactly 4 step periods (32 cycles), then returns to 0.
- **Direction change:** in TURN_L at `seq = 1`, switch `sw_left` → `sw_right` → `left` remains until the `seq = 3` step; the next step gives `right = 1`, `left = 0`.
- **Hazard:**
  - In TURN_R at `seq = 1`, assert `sw_hzd` → at the first step after debounce, `hzd = 1`, `right = 0`. Release `sw_hzd` with no turn request → `hzd = 0` at the next step.
  - `sw_left` and `sw_right` both asserted → `hzd = 1`, `left = right = 0`.
- **Brake and reset:** `sw_brk` with an active left turn → `brk = 1` and `left = 1` simultaneously. Assert `rst = 0` mid-cycle → all outputs 0 before the next clk edge. After release, the first `step` is at cycle 8.
